sipo_deserializer: RTL and testbench
====================================

# sipo_deserializer

Serial-in, parallel-out word assembler for the lab counter/shifter datapath. It captures a WIDTH-bit word one bit per enabled clock, in either MSB-first or LSB-first order. It presents the completed word on a registered parallel output with a valid/ready handshake. It is the receive side of the datapath's shift-register chain: it turns a bit stream back into a parallel nibble that the shifter and counter stages can load.

## Interface
- WIDTH, 4, word length in bits (≥2).
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  reset, synchronous, active-high.
- start  input  1  one-cycle frame-start strobe; opens or restarts a frame.
- msb_first  input  1  bit order for the frame (1 = MSB first); sampled only on the start cycle.
- en  input  1  bit strobe; sin is captured on a cycle with en=1 while a frame is open.
- sin  input  1  serial data bit.
- dout  output  WIDTH  last completed word; holds its value until the next word loads.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout when dout_valid=1.
- busy  output  1  a frame is open (state SHIFT).
- overrun  output  1  sticky flag: a completed word was dropped because dout was still occupied.

## Operation
- State IDLE:
  - start=1 → clear the shift register and bit count, latch msb_first into the order register, go to SHIFT.
  - en is ignored.
- State SHIFT, on a cycle with en=1 and start=0:
  - msb_first latched = 1: sr ← {sr[WIDTH-2:0], sin}.
  - msb_first latched = 0: sr ← {sin, sr[WIDTH-1:1]}.
  - count increments.
- Word completion is the en cycle with count = WIDTH-1. The assembled word includes that bit. State returns to IDLE.
  - dout_valid=0, or dout_valid=1 with dout_ready=1 in the same cycle → dout ← word, dout_valid ← 1.
  - Otherwise the word is discarded, overrun ← 1, and dout/dout_valid are unchanged.
- start=1 while in SHIFT aborts the partial frame: count cleared, sr cleared, msb_first re-latched, state stays SHIFT. start has priority over en, so no bit is captured on a start cycle.
- Handshake: dout_valid=1 and dout_ready=1 with no completion in that cycle → dout_valid ← 0, dout unchanged.
- overrun is cleared only by reset.
- count width is clog2(WIDTH) bits; it never exceeds WIDTH-1.

## Timing
- Reset values (after a reset edge): dout=0, dout_valid=0, busy=0, overrun=0, state IDLE, count=0, sr=0.
- Reset takes priority over every other input in the same cycle.
- Reset mid-frame drops the partial word and does not set overrun.
- busy rises the cycle after the start edge and falls the cycle after the final-bit edge.
- Minimum frame length is 1 start cycle plus WIDTH en cycles. en gaps stretch the frame with no limit.
- dout and dout_valid update on the clock edge that captures the final bit, so they are visible in the following cycle. Latency from final bit to dout_valid is 1 cycle.
- Back-to-back frames are supported: the next start may arrive the cycle after completion.
- The consumer sees dout_valid stay high continuously when it holds dout_ready=0.
- A completion and a handshake in the same cycle load the new word with dout_valid staying 1, and do not set overrun.

## Test plan
- MSB-first load (WIDTH=4):
  - Stimulus: reset; start with msb_first=1; then en=1 with sin = 1,0,1,1.
  - Response: dout=4'b1011 and dout_valid=1 one cycle after the 4th bit; busy=0.
- LSB-first with gaps:
  - Stimulus: start with msb_first=0; bits 1,0,1,1 with en low for 2 cycles between each bit.
  - Response: dout=4'b1101; busy stays 1 throughout the gaps.
- Overrun:
  - Stimulus: complete word 4'b0011 with dout_ready=0; then complete word 4'b1100.
  - Response: dout stays 4'b0011; overrun=1.
  - Then pulse dout_ready → dout_valid=0; overrun stays 1.
- Completion coinciding with handshake:
  - Stimulus: dout_valid=1 with dout=4'b0110; the next word 4'b1001 completes in the same cycle dout_ready=1.
  - Response: dout=4'b1001; dout_valid=1; overrun=0.
- Restart mid-frame:
  - Stimulus: start; bits 1,1; then start (msb_first=1) asserted together with en=1 and sin=0; then bits 0,1,0,1.
  - Response: dout=4'b0101; the bit offered on the restart cycle is not captured.
- Reset mid-frame:
  - Stimulus: start; 2 bits; then reset.
  - Response: all outputs 0; a following full frame 1,1,1,1 gives dout=4'b1111 with overrun=0.

Source files
------------

// File: rtl/sipo_deserializer_if.sv
// Serial-in / parallel-out bus bundle: bit stream in, word handshake out.
interface sipo_deserializer_if #(
  parameter int WIDTH = 4
) ();

  logic             start;
  logic             msb_first;
  logic             en;
  logic             sin;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             busy;
  logic             overrun;

  // Producer/consumer side of the deserializer.
  modport master (
    output start, msb_first, en, sin, dout_ready,
    input  dout, dout_valid, busy, overrun
  );

  // The deserializer itself.
  modport slave (
    input  start, msb_first, en, sin, dout_ready,
    output dout, dout_valid, busy, overrun
  );

endinterface

// File: rtl/sipo_deserializer.sv
// Serial-in, parallel-out word assembler with valid/ready output and a
// sticky overrun flag for words dropped while dout is still occupied.
//
//   state | meaning
//   ------+--------------------------------------------------------
//   IDLE  | no frame open; waiting for start, en ignored
//   SHIFT | frame open; each en cycle shifts one bit into sr
module sipo_deserializer #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  sipo_deserializer_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sr, sr_n;
  logic [CW-1:0]    count, count_n;
  logic             msb_latched, msb_latched_n;
  logic [WIDTH-1:0] dout_q, dout_n;
  logic             valid_q, valid_n;
  logic             overrun_q, overrun_n;
  logic [WIDTH-1:0] word;

  // State and datapath registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      sr          <= '0;
      count       <= '0;
      msb_latched <= 1'b0;
      dout_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state       <= state_n;
      sr          <= sr_n;
      count       <= count_n;
      msb_latched <= msb_latched_n;
      dout_q      <= dout_n;
      valid_q     <= valid_n;
      overrun_q   <= overrun_n;
    end
  end

  // Next-state, shift, completion and handshake logic.
  always_comb begin
    state_n       = state;
    sr_n          = sr;
    count_n       = count;
    msb_latched_n = msb_latched;
    dout_n        = dout_q;
    valid_n       = valid_q;
    overrun_n     = overrun_q;

    // Word formed by the bit on sin this cycle, in the latched order.
    word = msb_latched ? {sr[WIDTH-2:0], bus.sin} : {bus.sin, sr[WIDTH-1:1]};

    // Plain consume; a completion below may override it.
    if (valid_q && bus.dout_ready) valid_n = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          sr_n          = '0;
          count_n       = '0;
          msb_latched_n = bus.msb_first;
          state_n       = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.start) begin
          // Restart: drop the partial word, no bit captured this cycle.
          sr_n          = '0;
          count_n       = '0;
          msb_latched_n = bus.msb_first;
        end else if (bus.en) begin
          sr_n = word;
          if (count == LAST) begin
            count_n = '0;
            state_n = IDLE;
            if (!valid_q || bus.dout_ready) begin
              dout_n  = word;
              valid_n = 1'b1;
            end else begin
              overrun_n = 1'b1;
            end
          end else begin
            count_n = count + CW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.busy       = (state == SHIFT);
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer (WIDTH=4) with hand-computed words.
module tb_sipo_deserializer;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  sipo_deserializer_if #(.WIDTH(4)) bus ();

  sipo_deserializer #(.WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; inputs and outputs are handled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic msb);
    bus.start     = 1'b1;
    bus.msb_first = msb;
    tick();
    bus.start     = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    bus.en  = 1'b1;
    bus.sin = b;
    tick();
    bus.en  = 1'b0;
  endtask

  task automatic consume();
    bus.dout_ready = 1'b1;
    tick();
    bus.dout_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.msb_first  = 1'b0;
    bus.en         = 1'b0;
    bus.sin        = 1'b0;
    bus.dout_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    check("rst_dout",    bus.dout,       32'h0);
    check("rst_valid",   bus.dout_valid, 32'h0);
    check("rst_busy",    bus.busy,       32'h0);
    check("rst_overrun", bus.overrun,    32'h0);

    // en while idle is ignored.
    send_bit(1'b1);
    check("idle_en_busy",  bus.busy,       32'h0);
    check("idle_en_valid", bus.dout_valid, 32'h0);

    // MSB-first 1,0,1,1 -> 1011.
    do_start(1'b1);
    check("msb_busy_rise", bus.busy, 32'h1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    check("msb_no_valid_early", bus.dout_valid, 32'h0);
    send_bit(1'b1);
    check("msb_dout",  bus.dout,       32'hB);
    check("msb_valid", bus.dout_valid, 32'h1);
    check("msb_busy",  bus.busy,       32'h0);
    tick();
    check("msb_valid_hold", bus.dout_valid, 32'h1);
    consume();
    check("msb_consumed", bus.dout_valid, 32'h0);
    check("msb_dout_kept", bus.dout,      32'hB);

    // LSB-first with 2-cycle en gaps: 1,0,1,1 -> 1101.
    do_start(1'b0);
    for (int i = 0; i < 4; i++) begin
      send_bit((i == 1) ? 1'b0 : 1'b1);
      if (i < 3) begin
        tick(); tick();
        check("lsb_gap_busy", bus.busy, 32'h1);
      end
    end
    check("lsb_dout",  bus.dout,       32'hD);
    check("lsb_valid", bus.dout_valid, 32'h1);
    consume();

    // Overrun: 0011 unconsumed, then 1100 is dropped.
    do_start(1'b1);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    check("ovr_first_dout", bus.dout,    32'h3);
    check("ovr_first_flag", bus.overrun, 32'h0);
    do_start(1'b1);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    check("ovr_dout_kept", bus.dout,       32'h3);
    check("ovr_valid",     bus.dout_valid, 32'h1);
    check("ovr_flag",      bus.overrun,    32'h1);
    consume();
    check("ovr_consumed", bus.dout_valid, 32'h0);
    check("ovr_sticky",   bus.overrun,    32'h1);
    do_reset();
    check("ovr_reset_clears", bus.overrun, 32'h0);

    // Completion coinciding with handshake: 0110 held, then 1001.
    do_start(1'b1);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    check("coin_first", bus.dout, 32'h6);
    do_start(1'b1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    bus.dout_ready = 1'b1;
    send_bit(1'b1);
    bus.dout_ready = 1'b0;
    check("coin_dout",    bus.dout,       32'h9);
    check("coin_valid",   bus.dout_valid, 32'h1);
    check("coin_overrun", bus.overrun,    32'h0);
    consume();

    // Restart mid-frame; bit offered with the restart is not captured.
    do_start(1'b0);
    send_bit(1'b1); send_bit(1'b1);
    bus.start = 1'b1; bus.msb_first = 1'b1; bus.en = 1'b1; bus.sin = 1'b0;
    tick();
    bus.start = 1'b0; bus.en = 1'b0;
    check("rst_frame_busy", bus.busy, 32'h1);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    check("restart_not_early", bus.dout_valid, 32'h0);
    send_bit(1'b1);
    check("restart_dout",  bus.dout,       32'h5);
    check("restart_valid", bus.dout_valid, 32'h1);
    consume();

    // Reset mid-frame, then full 1111 frame.
    do_start(1'b1);
    send_bit(1'b1); send_bit(1'b0);
    do_reset();
    check("midrst_dout",    bus.dout,       32'h0);
    check("midrst_valid",   bus.dout_valid, 32'h0);
    check("midrst_busy",    bus.busy,       32'h0);
    check("midrst_overrun", bus.overrun,    32'h0);
    for (int i = 0; i < 2; i++) send_bit(1'b1);
    check("midrst_no_resume", bus.dout_valid, 32'h0);
    do_start(1'b1);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    check("full_dout",    bus.dout,       32'hF);
    check("full_valid",   bus.dout_valid, 32'h1);
    check("full_overrun", bus.overrun,    32'h0);

    // Reset has priority over start in the same cycle.
    reset = 1'b1; bus.start = 1'b1;
    tick();
    reset = 1'b0; bus.start = 1'b0;
    check("rst_prio_busy",  bus.busy,       32'h0);
    check("rst_prio_valid", bus.dout_valid, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
